gp_dcmp_pwm: RTL and testbench

//  Clocked 8-bit digital comparator and complementary PWM stage with deadband.

---
 rtl/gp_dcmp_pwm.sv | 128 ++++++++++++
 tb/tb_gp_dcmp_pwm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gp_dcmp_pwm.sv
// rtl/gp_dcmp_pwm.sv - registered 8-bit comparator driving a complementary PWM pair with deadband
// Both outputs are decoded from the FSM state and registered with it, so they can never overlap.
module gp_dcmp_pwm #(
  parameter bit          GREATER_OR_EQUAL = 1'b1,
  parameter int unsigned DEADBAND         = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pwrdn_i,
  input  logic [7:0] inp_i,
  input  logic [7:0] inn_i,
  output logic       greater_o,
  output logic       equal_o,
  output logic       outp_o,
  output logic       outn_o
);

  if (DEADBAND < 1 || DEADBAND > 15) begin : g_bad_deadband
    $error("gp_dcmp_pwm: DEADBAND must be in 1..15");
  end

  localparam logic [3:0] DCNT_LOAD = DEADBAND[3:0];

  typedef enum logic [1:0] {
    LOW_ON    = 2'd0,
    DEAD_RISE = 2'd1,
    HIGH_ON   = 2'd2,
    DEAD_FALL = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] dcnt_q;
  logic       greater_q;
  logic       equal_q;
  logic       outp_q;
  logic       outn_q;
  logic       greater_d;
  logic       equal_d;

  always_comb begin
    greater_d = GREATER_OR_EQUAL ? (inp_i >= inn_i) : (inp_i > inn_i);
    equal_d   = (inp_i == inn_i);
  end

  // The FSM steers on the registered compare result, i.e. the value loaded one edge earlier.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      state_q   <= DEAD_FALL;
      dcnt_q    <= DCNT_LOAD;
      outp_q    <= 1'b0;
      outn_q    <= 1'b0;
    end else if (pwrdn_i) begin
      state_q <= DEAD_FALL;
      dcnt_q  <= DCNT_LOAD;
      outp_q  <= 1'b0;
      outn_q  <= 1'b0;
    end else begin
      greater_q <= greater_d;
      equal_q   <= equal_d;
      case (state_q)
        LOW_ON: begin
          if (greater_q) begin
            state_q <= DEAD_RISE;
            dcnt_q  <= DCNT_LOAD;
            outp_q  <= 1'b0;
            outn_q  <= 1'b0;
          end else begin
            outp_q <= 1'b0;
            outn_q <= 1'b1;
          end
        end
        DEAD_RISE: begin
          outn_q <= 1'b0;
          if (!greater_q) begin
            state_q <= DEAD_FALL;
            dcnt_q  <= DCNT_LOAD;
            outp_q  <= 1'b0;
          end else if (dcnt_q == 4'd1) begin
            state_q <= HIGH_ON;
            outp_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q - 4'd1;
            outp_q <= 1'b0;
          end
        end
        HIGH_ON: begin
          outn_q <= 1'b0;
          if (!greater_q) begin
            state_q <= DEAD_FALL;
            dcnt_q  <= DCNT_LOAD;
            outp_q  <= 1'b0;
          end else begin
            outp_q <= 1'b1;
          end
        end
        DEAD_FALL: begin
          outp_q <= 1'b0;
          if (greater_q) begin
            // Aborting restarts the full dead time toward the other side.
            state_q <= DEAD_RISE;
            dcnt_q  <= DCNT_LOAD;
            outn_q  <= 1'b0;
          end else if (dcnt_q == 4'd1) begin
            state_q <= LOW_ON;
            outn_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q - 4'd1;
            outn_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DEAD_FALL;
          dcnt_q  <= DCNT_LOAD;
          outp_q  <= 1'b0;
          outn_q  <= 1'b0;
        end
      endcase
    end
  end

  assign greater_o = greater_q;
  assign equal_o   = equal_q;
  assign outp_o    = outp_q;
  assign outn_o    = outn_q;

endmodule

// File: tb/tb_gp_dcmp_pwm.sv
// tb/tb_gp_dcmp_pwm.sv - self-checking bench for gp_dcmp_pwm across three parameter sets
module tb_gp_dcmp_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwrdn;
  logic [7:0] inp;
  logic [7:0] inn;
  logic [2:0] gr, eq, op, on;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance 0: >=, deadband 3; instance 1: >, deadband 4; instance 2: >=, deadband 1.
  gp_dcmp_pwm #(.GREATER_OR_EQUAL(1'b1), .DEADBAND(3)) u_a (
    .clk_i(clk), .rst_i(rst), .pwrdn_i(pwrdn), .inp_i(inp), .inn_i(inn),
    .greater_o(gr[0]), .equal_o(eq[0]), .outp_o(op[0]), .outn_o(on[0]));
  gp_dcmp_pwm #(.GREATER_OR_EQUAL(1'b0), .DEADBAND(4)) u_b (
    .clk_i(clk), .rst_i(rst), .pwrdn_i(pwrdn), .inp_i(inp), .inn_i(inn),
    .greater_o(gr[1]), .equal_o(eq[1]), .outp_o(op[1]), .outn_o(on[1]));
  gp_dcmp_pwm #(.GREATER_OR_EQUAL(1'b1), .DEADBAND(1)) u_c (
    .clk_i(clk), .rst_i(rst), .pwrdn_i(pwrdn), .inp_i(inp), .inn_i(inn),
    .greater_o(gr[2]), .equal_o(eq[2]), .outp_o(op[2]), .outn_o(on[2]));

  always #5 clk = ~clk;

  function automatic int db_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 4 : 1;
  endfunction

  function automatic bit goe_of(input int i);
    return (i != 1);
  endfunction

  // Reference: a side turns on once the FSM has seen that compare value on DEADBAND+1
  // consecutive edges; a reset or power-down edge counts as seeing "low side".
  logic mg [3];
  logic me [3];
  int   run_val [3];
  int   run_len [3];
  int   gap [3];
  int   last_side [3];

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %b want %b at %0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst || pwrdn) begin
        run_val[i] = 0;
        run_len[i] = 1;
      end else if (int'(mg[i]) == run_val[i]) begin
        run_len[i]++;
      end else begin
        run_val[i] = int'(mg[i]);
        run_len[i] = 1;
      end
      if (rst) begin
        mg[i] = 1'b0;
        me[i] = 1'b0;
      end else if (!pwrdn) begin
        mg[i] = goe_of(i) ? (inp >= inn) : (inp > inn);
        me[i] = (inp == inn);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("greater", i, gr[i], mg[i]);
      chk("equal", i, eq[i], me[i]);
      chk("outp", i, op[i], (run_val[i] == 1) && (run_len[i] >= db_of(i) + 1));
      chk("outn", i, on[i], (run_val[i] == 0) && (run_len[i] >= db_of(i) + 1));
      chk("overlap", i, op[i] & on[i], 1'b0);
      if (op[i] || on[i]) begin
        if (last_side[i] >= 0 && last_side[i] != int'(op[i]))
          chk("gap_ok", i, gap[i] >= db_of(i), 1'b1);
        last_side[i] = int'(op[i]);
        gap[i] = 0;
      end else begin
        gap[i]++;
      end
    end
  endtask

  typedef struct {
    logic       pd;
    logic [7:0] a;
    logic [7:0] b;
    logic       g_ge;
    logic       g_gt;
    logic       e;
  } vec_t;

  vec_t vecs [9];
  bit   seen;

  initial begin
    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h80, 8'h40, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      mg[i] = 1'b0; me[i] = 1'b0; run_val[i] = 0; run_len[i] = 1;
      gap[i] = 0; last_side[i] = -1;
    end

    // Reset for two cycles, then the first low-side phase after the dead time.
    rst = 1'b1; pwrdn = 1'b0; inp = 8'h10; inn = 8'h20;
    step(); step();
    chk("rst_greater", 0, gr[0], 1'b0);
    chk("rst_outs", 0, op[0] | on[0], 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("rel_outn", 0, on[0], k >= 3);
      chk("rel_outn", 1, on[1], k >= 4);
    end

    // Rising compare from LOW_ON with deadband 3.
    inp = 8'h80; inn = 8'h40;
    step();
    chk("t2_greater", 0, gr[0], 1'b1);
    step();
    chk("t2_outn_off", 0, on[0], 1'b0);
    step(); step();
    chk("t2_outp_early", 0, op[0], 1'b0);
    step();
    chk("t2_outp_on", 0, op[0], 1'b1);

    // Compare-stage vectors, including the power-down hold row.
    for (int v = 0; v < 9; v++) begin
      pwrdn = vecs[v].pd; inp = vecs[v].a; inn = vecs[v].b;
      step();
      chk("vec_g_ge", v, gr[0], vecs[v].g_ge);
      chk("vec_g_gt", v, gr[1], vecs[v].g_gt);
      chk("vec_eq", v, eq[0], vecs[v].e);
      chk("vec_eq", v, eq[1], vecs[v].e);
    end
    pwrdn = 1'b0; inp = 8'h10; inn = 8'h20;
    for (int k = 0; k < 10; k++) step();

    // Two-cycle compare pulse aborts the rise on the deadband-4 instance.
    inp = 8'h80; inn = 8'h40;
    step();
    chk("t4_outp", 1, op[1], 1'b0);
    step();
    chk("t4_outp", 1, op[1], 1'b0);
    inp = 8'h10; inn = 8'h20;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("t4_outp", 1, op[1], 1'b0);
      chk("t4_outn", 1, on[1], k >= 7);
    end

    // Power-down while the high side is on.
    inp = 8'h80; inn = 8'h40;
    for (int k = 0; k < 10; k++) step();
    chk("t5_high", 1, op[1], 1'b1);
    pwrdn = 1'b1; inp = 8'h10; inn = 8'h20;
    step();
    chk("t5_outp", 1, op[1], 1'b0);
    chk("t5_outn", 1, on[1], 1'b0);
    chk("t5_hold", 1, gr[1], 1'b1);
    step(); step();
    chk("t5_hold", 1, gr[1], 1'b1);
    pwrdn = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      chk("t5_no_outp", 1, op[1], 1'b0);
      seen = on[1];
    end
    chk("t5_low_reached", 1, seen, 1'b1);

    // Random soak with sticky operands so full ON phases occur.
    for (int k = 0; k < 10000; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      pwrdn = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) begin
        inp = 8'($urandom);
        inn = ($urandom_range(0, 5) == 0) ? inp : 8'($urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
